iir_sos_ctrl: RTL and testbench
===============================

IIR_SOS_CTRL -- requirements
Module: iir_sos_ctrl

Interface
REQ-001 SHALL have parameter N_SECT, default 2: number of cascaded biquad sections driven.
REQ-002 SHALL have parameter SAMP_W, default 27: sample width, SAMP_WH+SAMP_FR (4+23).
REQ-003 SHALL have parameter COEFF_W, default 16: coefficient width, COEFF_WH+COEFF_FR (2+14).
REQ-004 SHALL have one clock and an asynchronous active-low reset; ports: clk  in  1  clock; nrst  in  1  async active-low reset.
REQ-005 SHALL have ports: cfg_start  in  1  coefficient-load request pulse; ld_valid  in  1  load word valid; ld_ready  out  1  load word accepted; ld_data  in  COEFF_W  coefficient word.
REQ-006 SHALL have ports: cfg_done  out  1  one-cycle load-complete pulse; coef_ok  out  1  full coefficient set loaded.
REQ-007 SHALL have ports: c_we  out  1  coefficient write strobe; c_sect  out  N_SECT  one-hot section select; c_addr  out  2  00=a0, 01=a1, 10=b, 11=K; c_in  out  COEFF_W  coefficient data.
REQ-008 SHALL have ports: s_valid  in  1  input sample valid; s_ready  out  1  sample accepted; s_data  in  SAMP_W  input sample; din  out  SAMP_W  registered sample to section 0.
REQ-009 SHALL have ports: ce  out  1  compute enable broadcast; mult_sel  out  1  feedback-tap select broadcast; casc_dout  in  SAMP_W  last-section output; o_valid  out  1  output valid pulse; o_data  out  SAMP_W  output sample.

Function
REQ-010 SHALL implement FSM states IDLE, LOAD, PREP, C0, C1, END.
REQ-011 In IDLE, cfg_start SHALL move to LOAD, clear coef_ok and clear the fill counter; cfg_start outside IDLE SHALL be ignored; cfg_start has priority over s_valid.
REQ-012 ld_ready SHALL be 1 only in LOAD; a word transfers when ld_valid && ld_ready.
REQ-013 Words SHALL be consumed in order: section 0..N_SECT-1, each c_addr 00,01,10,11; 4*N_SECT words total.
REQ-014 Each transferred word SHALL produce c_we=1 for exactly one cycle, the cycle after transfer, with c_in, c_addr and c_sect registered and valid in the same cycle; otherwise c_we=0.
REQ-015 After the final word, FSM SHALL return to IDLE, and cfg_done and coef_ok SHALL rise together in the cycle of the final c_we; ld_valid gaps SHALL stall without error.
REQ-016 s_ready SHALL be 1 in IDLE and END when coef_ok=1 and cfg_start=0; acceptance SHALL latch s_data into din and go to PREP.
REQ-017 Per-sample burst SHALL be: PREP ce=0, mult_sel=0; C0 ce=1, mult_sel=1; C1 ce=1, mult_sel=0; END ce=0, mult_sel=0; END returns to IDLE or, on acceptance, PREP (4-cycle throughput).
REQ-018 In IDLE and LOAD, ce=0 and mult_sel=0; din SHALL hold its value outside acceptance.
REQ-019 Fill counter (saturating at N_SECT-1) SHALL increment each END; in the cycle after END, when the counter was already N_SECT-1 at END, o_data SHALL capture casc_dout, with o_valid=1 for exactly the following cycle.
REQ-020 Output latency from acceptance of sample k to its o_valid: N_SECT-1 bursts plus 6 cycles; earlier bursts (pipeline fill) SHALL produce no o_valid.

Reset
REQ-021 nrst low SHALL immediately force IDLE, ld_ready=0, cfg_done=0, coef_ok=0, c_we=0, c_sect=0, c_addr=0, c_in=0, din=0, ce=0, mult_sel=0, o_valid=0, o_data=0, word and fill counters 0.
REQ-022 Reset mid-load or mid-burst SHALL abandon the operation; a new cfg_start is required before samples are accepted.

Structure
REQ-023 State encoding, c_addr codes and burst length SHALL live in shared package iir_pkg.
REQ-024 Coefficient-load sequencer SHALL be a sub-module iir_coef_loader (word counter, c_* register outputs, cfg_done).

Verification (N_SECT=2)
REQ-025 Load 8 words 0x1000..0x1007 with ld_valid always high -> c_we pulses 8 times; c_sect 01,01,01,01,10,10,10,10; c_addr 0,1,2,3,0,1,2,3; cfg_done once with the 8th c_we.
REQ-026 s_valid with coef_ok=0 -> s_ready=0, ce stays 0.
REQ-027 Continuous s_valid, s_data 1..5 after load -> ce pattern 0110 repeating, mult_sel 0100, first o_valid after 2nd burst, 4 o_valid pulses total.
REQ-028 cfg_start during C0 -> ignored, burst completes, coef_ok stays 1.
REQ-029 nrst low in LOAD after 3 words -> all outputs 0, coef_ok=0; subsequent s_valid not accepted.
REQ-030 cfg_start and s_valid both high in IDLE -> LOAD entered, s_ready=0, no ce.

Source files
------------

// File: rtl/iir_pkg.sv
// iir_pkg: shared types for the biquad cascade controller.
// FSM state encoding, coefficient slot codes, burst shape.
package iir_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREP,
    S_C0,
    S_C1,
    S_END
  } state_t;

  typedef enum logic [1:0] {
    CA_A0 = 2'b00,
    CA_A1 = 2'b01,
    CA_B  = 2'b10,
    CA_K  = 2'b11
  } caddr_t;

  localparam int BURST_LEN      = 4;
  localparam int WORDS_PER_SECT = 4;

  // Word order inside one section: a0, a1, b, K.
  function automatic caddr_t addr_of(
    input logic [1:0] slot
  );
    caddr_t a;
    unique case (slot)
      2'd0:    a = CA_A0;
      2'd1:    a = CA_A1;
      2'd2:    a = CA_B;
      default: a = CA_K;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/iir_sos_ctrl_if.sv
// iir_ld_if: valid/ready coefficient word stream.
// master drives ld_valid/ld_data, slave drives ld_ready.
interface iir_ld_if #(
  parameter int W = 16
);
  logic         ld_valid;
  logic         ld_ready;
  logic [W-1:0] ld_data;

  modport master (
    output ld_valid,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/iir_coef_loader.sv
// iir_coef_loader: streams 4*N_SECT words into section regs.
// Ports: clk/nrst, i_clr, i_en, ld (slave), o_last, c_*, cfg_done.
module iir_coef_loader
  import iir_pkg::*;
#(
  parameter int N_SECT  = 2,
  parameter int COEFF_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i_clr,
  input  logic               i_en,
  iir_ld_if.slave            ld,
  output logic               o_last,
  output logic               c_we,
  output logic [N_SECT-1:0]  c_sect,
  output logic [1:0]         c_addr,
  output logic [COEFF_W-1:0] c_in,
  output logic               cfg_done
);

  localparam int NW = WORDS_PER_SECT * N_SECT;
  localparam int CW = $clog2(NW);

  logic [CW-1:0]     r_cnt;
  logic              w_xfer;
  logic              w_last;
  logic [N_SECT-1:0] w_sel;

  assign ld.ld_ready = i_en;
  assign w_xfer      = ld.ld_valid && i_en;
  assign w_last      = w_xfer && (r_cnt == CW'(NW - 1));
  assign o_last      = w_last;

  // Upper counter bits pick the section, low two the slot.
  assign w_sel = N_SECT'(1) << (r_cnt >> 2);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt    <= '0;
      c_we     <= 1'b0;
      c_sect   <= '0;
      c_addr   <= '0;
      c_in     <= '0;
      cfg_done <= 1'b0;
    end else begin
      c_we     <= w_xfer;
      cfg_done <= w_last;
      if (i_clr) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
      if (w_xfer) begin
        c_in   <= ld.ld_data;
        c_addr <= addr_of(r_cnt[1:0]);
        c_sect <= w_sel;
      end
    end
  end

endmodule

// File: rtl/iir_sos_ctrl.sv
// iir_sos_ctrl: coefficient load + per-sample burst sequencer.
// Ports: clk/nrst, cfg/ld load, c_* writes, s_* in, ce/mult_sel, o_*.
module iir_sos_ctrl
  import iir_pkg::*;
#(
  parameter int N_SECT  = 2,
  parameter int SAMP_W  = 27,
  parameter int COEFF_W = 16
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               cfg_start,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [COEFF_W-1:0] ld_data,
  output logic               cfg_done,
  output logic               coef_ok,
  output logic               c_we,
  output logic [N_SECT-1:0]  c_sect,
  output logic [1:0]         c_addr,
  output logic [COEFF_W-1:0] c_in,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SAMP_W-1:0]  s_data,
  output logic [SAMP_W-1:0]  din,
  output logic               ce,
  output logic               mult_sel,
  input  logic [SAMP_W-1:0]  casc_dout,
  output logic               o_valid,
  output logic [SAMP_W-1:0]  o_data
);

  localparam int FW = (N_SECT > 1) ? $clog2(N_SECT) : 1;
  localparam logic [FW-1:0] FILL_MAX = FW'(N_SECT - 1);

  state_t        r_state;
  state_t        w_next;
  logic [FW-1:0] r_fill;
  logic          r_cap;
  logic          w_cfg;
  logic          w_acc;
  logic          w_last;
  logic          w_end;

  iir_ld_if #(.W(COEFF_W)) u_ld ();

  assign u_ld.ld_valid = ld_valid;
  assign u_ld.ld_data  = ld_data;
  assign ld_ready      = u_ld.ld_ready;

  iir_coef_loader #(
    .N_SECT  (N_SECT),
    .COEFF_W (COEFF_W)
  ) u_loader (
    .clk      (clk),
    .nrst     (nrst),
    .i_clr    (w_cfg),
    .i_en     (r_state == S_LOAD),
    .ld       (u_ld.slave),
    .o_last   (w_last),
    .c_we     (c_we),
    .c_sect   (c_sect),
    .c_addr   (c_addr),
    .c_in     (c_in),
    .cfg_done (cfg_done)
  );

  // A load request outranks a waiting sample.
  assign w_cfg   = (r_state == S_IDLE) && cfg_start;
  assign s_ready = ((r_state == S_IDLE) || (r_state == S_END))
                   && coef_ok && !cfg_start;
  assign w_acc   = s_valid && s_ready;
  assign w_end   = (r_state == S_END);

  always_comb begin
    w_next   = r_state;
    ce       = 1'b0;
    mult_sel = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cfg) begin
          w_next = S_LOAD;
        end else if (w_acc) begin
          w_next = S_PREP;
        end
      end
      S_LOAD: begin
        if (w_last) begin
          w_next = S_IDLE;
        end
      end
      S_PREP: begin
        w_next = S_C0;
      end
      S_C0: begin
        w_next   = S_C1;
        ce       = 1'b1;
        mult_sel = 1'b1;
      end
      S_C1: begin
        w_next = S_END;
        ce     = 1'b1;
      end
      S_END: begin
        w_next = w_acc ? S_PREP : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      coef_ok <= 1'b0;
      din     <= '0;
    end else begin
      r_state <= w_next;
      if (w_cfg) begin
        coef_ok <= 1'b0;
      end else if (w_last) begin
        coef_ok <= 1'b1;
      end
      if (w_acc) begin
        din <= s_data;
      end
    end
  end

  // Bursts before the pipe is full yield no output; once
  // saturated, each END hands one result to the next cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fill  <= '0;
      r_cap   <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      if (w_cfg) begin
        r_fill <= '0;
      end else if (w_end && (r_fill != FILL_MAX)) begin
        r_fill <= r_fill + FW'(1);
      end
      r_cap   <= w_end && (r_fill == FILL_MAX);
      o_valid <= r_cap;
      if (r_cap) begin
        o_data <= casc_dout;
      end
    end
  end

endmodule

// File: tb/tb_iir_sos_ctrl.sv
// tb_iir_sos_ctrl: random stimulus, scoreboarded checks.
// Drives load/sample streams; model predicts all outputs.
module tb_iir_sos_ctrl;
  import iir_pkg::*;

  localparam int N  = 2;
  localparam int SW = 27;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          cfg_start = 1'b0;
  logic          s_valid = 1'b0;
  logic [SW-1:0] s_data = '0;
  logic [SW-1:0] casc_dout;
  logic          cfg_done;
  logic          coef_ok;
  logic          c_we;
  logic [N-1:0]  c_sect;
  logic [1:0]    c_addr;
  logic [CW-1:0] c_in;
  logic          s_ready;
  logic [SW-1:0] din;
  logic          ce;
  logic          mult_sel;
  logic          o_valid;
  logic [SW-1:0] o_data;

  iir_ld_if #(.W(CW)) ld_bus ();

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SW-1:0] casc_at(input int c);
    return SW'(c * 32'h01F3_A5C7 + 32'h155);
  endfunction

  assign casc_dout = casc_at(cyc);

  iir_sos_ctrl #(
    .N_SECT  (N),
    .SAMP_W  (SW),
    .COEFF_W (CW)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cfg_start (cfg_start),
    .ld_valid  (ld_bus.ld_valid),
    .ld_ready  (ld_bus.ld_ready),
    .ld_data   (ld_bus.ld_data),
    .cfg_done  (cfg_done),
    .coef_ok   (coef_ok),
    .c_we      (c_we),
    .c_sect    (c_sect),
    .c_addr    (c_addr),
    .c_in      (c_in),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .din       (din),
    .ce        (ce),
    .mult_sel  (mult_sel),
    .casc_dout (casc_dout),
    .o_valid   (o_valid),
    .o_data    (o_data)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    int            c;
    logic [N-1:0]  sect;
    logic [1:0]    addr;
    logic [CW-1:0] d;
  } cw_t;

  typedef struct {
    int            c;
    logic [SW-1:0] d;
  } ov_t;

  cw_t q_cw[$];
  ov_t q_ov[$];

  // Model state: what the spec says the block is doing.
  bit            m_load = 0;
  bit            m_ok = 0;
  int            m_wcnt = 0;
  int            m_nacc = 0;
  int            m_acc = -100;
  int            m_bend = -100;
  int            m_done_at = -100;
  logic [SW-1:0] m_din = '0;

  always @(negedge clk) begin
    logic rdy_e;
    cw_t  it;
    ov_t  ot;
    if (!nrst) begin
      m_load = 0; m_ok = 0; m_wcnt = 0; m_nacc = 0;
      m_acc = -100; m_bend = -100; m_done_at = -100;
      m_din = '0;
      q_cw.delete();
      q_ov.delete();
      chk("rst_ctl", {ld_bus.ld_ready, cfg_done, coef_ok,
          c_we, c_sect, c_addr, ce, mult_sel, o_valid,
          s_ready}, 64'd0);
      chk("rst_data", {c_in, din}, 64'd0);
      chk("rst_odata", o_data, 64'd0);
    end else begin
      rdy_e = m_ok && !cfg_start && !m_load
              && (cyc >= m_bend);
      chk("s_ready", s_ready, rdy_e);
      chk("ld_ready", ld_bus.ld_ready, m_load);
      chk("ce", ce, (cyc == m_acc + 2) || (cyc == m_acc + 3));
      chk("mult_sel", mult_sel, cyc == m_acc + 2);
      chk("cfg_done", cfg_done, cyc == m_done_at);
      chk("coef_ok", coef_ok, m_ok);
      chk("din", din, m_din);
      if (cfg_start && !m_load && cyc > m_bend) begin
        m_load = 1; m_ok = 0; m_wcnt = 0; m_nacc = 0;
      end else if (m_load) begin
        if (ld_bus.ld_valid) begin
          it.c    = cyc + 1;
          it.sect = N'(1) << (m_wcnt / 4);
          it.addr = 2'(m_wcnt % 4);
          it.d    = ld_bus.ld_data;
          q_cw.push_back(it);
          m_wcnt++;
          if (m_wcnt == 4 * N) begin
            m_load = 0; m_ok = 1; m_done_at = cyc + 1;
          end
        end
      end else if (s_valid && rdy_e) begin
        m_acc  = cyc;
        m_bend = cyc + BURST_LEN;
        m_din  = s_data;
        if (m_nacc >= N - 1) begin
          ot.c = cyc + 6;
          ot.d = casc_at(cyc + 5);
          q_ov.push_back(ot);
        end
        m_nacc++;
      end
    end
  end

  // Monitor: pops an expectation whenever the DUT presents one.
  always @(negedge clk) begin
    cw_t e;
    ov_t o;
    if (nrst) begin
      if (c_we) begin
        if (q_cw.size() == 0) begin
          chk("c_we_unexpected", 1, 0);
        end else begin
          e = q_cw.pop_front();
          chk("c_we_cyc", cyc, e.c);
          chk("c_sect", c_sect, e.sect);
          chk("c_addr", c_addr, e.addr);
          chk("c_in", c_in, e.d);
        end
      end
      if (o_valid) begin
        if (q_ov.size() == 0) begin
          chk("o_valid_unexpected", 1, 0);
        end else begin
          o = q_ov.pop_front();
          chk("o_valid_cyc", cyc, o.c);
          chk("o_data", o_data, o.d);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    nrst = 1'b0;
    cfg_start = 1'b0;
    s_valid = 1'b0;
    ld_bus.ld_valid = 1'b0;
    repeat (n) tick();
    nrst = 1'b1;
  endtask

  task automatic load(input logic [CW-1:0] base,
                      input bit rnd, input int gapmax,
                      input int nw, input bit with_s);
    int tmo;
    cfg_start = 1'b1;
    if (with_s) begin
      s_valid = 1'b1;
      s_data  = SW'($urandom);
    end
    tick();
    cfg_start = 1'b0;
    s_valid = 1'b0;
    for (int w = 0; w < nw; w++) begin
      if (gapmax > 0) begin
        ld_bus.ld_valid = 1'b0;
        repeat ($urandom_range(gapmax, 0)) tick();
      end
      ld_bus.ld_valid = 1'b1;
      ld_bus.ld_data  = rnd ? CW'($urandom) : base + CW'(w);
      tmo = 0;
      while (!ld_bus.ld_ready && tmo < 20) begin
        tick();
        tmo++;
      end
      if (tmo >= 20) chk("ld_timeout", 1, 0);
      tick();
    end
    ld_bus.ld_valid = 1'b0;
  endtask

  task automatic send(input int n, input int gapmax,
                      input bit seq,
                      input logic [SW-1:0] first);
    int tmo;
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = seq ? first + SW'(k) : SW'($urandom);
      tmo = 0;
      while (!s_ready && tmo < 20) begin
        tick();
        tmo++;
      end
      if (tmo >= 20) begin
        chk("s_timeout", 1, 0);
        break;
      end
      tick();
      if (gapmax > 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(gapmax, 0)) tick();
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    ld_bus.ld_valid = 1'b0;
    ld_bus.ld_data  = '0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();

    // Samples offered before any coefficients are loaded.
    s_valid = 1'b1;
    s_data  = SW'(42);
    repeat (5) tick();
    s_valid = 1'b0;
    tick();

    // Ordered load 0x1000..0x1007, valid held high.
    load(16'h1000, 0, 0, 8, 0);
    repeat (2) tick();

    // Back-to-back samples 1..5.
    send(5, 0, 1, SW'(1));
    repeat (12) tick();

    // cfg_start arriving in C0 must be ignored.
    s_valid = 1'b1;
    s_data  = SW'(7);
    tick();
    s_valid = 1'b0;
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    repeat (10) tick();

    // cfg_start and s_valid together; gappy random load.
    load('0, 1, 3, 8, 1);
    repeat (2) tick();
    send(20, 3, 0, '0);
    repeat (12) tick();
    send(6, 0, 0, '0);
    repeat (12) tick();

    // Reset in the middle of a load.
    load(16'h2000, 0, 0, 3, 0);
    do_reset(2);
    s_valid = 1'b1;
    s_data  = SW'(99);
    repeat (5) tick();
    s_valid = 1'b0;
    tick();

    load('0, 1, 2, 8, 0);
    repeat (2) tick();
    send(4, 0, 0, '0);
    repeat (12) tick();

    // Reset in the middle of a burst.
    s_valid = 1'b1;
    s_data  = SW'($urandom);
    tick();
    s_valid = 1'b0;
    tick();
    do_reset(2);
    tick();

    load('0, 1, 1, 8, 0);
    repeat (2) tick();
    send(8, 2, 0, '0);
    repeat (15) tick();

    chk("cw_pending", q_cw.size(), 0);
    chk("ov_pending", q_ov.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
